// File: rtl/led_mode_pkg.sv
// rtl/led_mode_pkg.sv - mode codes and clock-derived helpers for the LED mode controller
package led_mode_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SLOW    = 3'd2;
  localparam logic [MODE_W-1:0] MODE_FAST    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 3'd4;

  // System clock cycles in one millisecond
  function automatic int cyc_per_ms(input int freq);
    return freq / 1000;
  endfunction

endpackage

// File: rtl/led_breath.sv
// rtl/led_breath.sv - PWM breathing engine: frame counter, triangular duty ramp, frame-aligned duty latch
module led_breath #(
  parameter int CYC_MS    = 50_000,
  parameter int BREATH_MS = 2000,
  parameter int PWM_BITS  = 6
) (
  input  logic sclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic pwm_out
);

  localparam int DMAX     = (2 ** PWM_BITS) - 1;
  localparam int STEP_CYC = (CYC_MS * BREATH_MS) / (2 * DMAX);
  localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

  localparam logic [PWM_BITS-1:0] DMAX_V    = PWM_BITS'(DMAX);
  localparam logic [PWM_BITS-1:0] RAMP_TOP  = PWM_BITS'(DMAX - 1);
  localparam logic [PWM_BITS-1:0] RAMP_ONE  = PWM_BITS'(1);
  localparam logic [STEP_W-1:0]   STEP_TERM = STEP_W'(STEP_CYC - 1);

  if (STEP_CYC < 1) begin : g_bad_step
    $error("led_breath: breathe step interval rounds to zero cycles");
  end

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                dir_down_q, dir_down_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;

  logic pwm_wrap;
  logic step_wrap;

  assign pwm_wrap  = (pwm_cnt_q == DMAX_V);
  assign step_wrap = (step_q == STEP_TERM);

  // Next state: the ramp walks 0..DMAX..0 one step per wrap; duty is captured as the frame restarts
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q;
    step_d     = step_q;
    ramp_d     = ramp_q;
    dir_down_d = dir_down_q;
    duty_d     = duty_q;
    if (clr) begin
      pwm_cnt_d  = '0;
      step_d     = '0;
      ramp_d     = '0;
      dir_down_d = 1'b0;
      duty_d     = '0;
    end else if (en) begin
      pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
      if (pwm_wrap) duty_d = ramp_q;
      if (step_wrap) begin
        step_d = '0;
        if (!dir_down_q) begin
          ramp_d = ramp_q + 1'b1;
          if (ramp_q == RAMP_TOP) dir_down_d = 1'b1;
        end else begin
          ramp_d = ramp_q - 1'b1;
          if (ramp_q == RAMP_ONE) dir_down_d = 1'b0;
        end
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // State register for the PWM and ramp counters
  always_ff @(posedge sclk) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      step_q     <= '0;
      ramp_q     <= '0;
      dir_down_q <= 1'b0;
      duty_q     <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_q     <= step_d;
      ramp_q     <= ramp_d;
      dir_down_q <= dir_down_d;
      duty_q     <= duty_d;
    end
  end

  assign pwm_out = (pwm_cnt_q < duty_q);

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - key-driven LED mode controller: off, on, slow blink, fast blink, breathing
module led_mode_ctrl
  import led_mode_pkg::*;
#(
  parameter int SCLK_FREQ = 50_000_000,
  parameter int SLOW_MS   = 500,
  parameter int FAST_MS   = 100,
  parameter int BREATH_MS = 2000,
  parameter int PWM_BITS  = 6
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              key_pulse,
  output logic              led,
  output logic [MODE_W-1:0] mode
);

  localparam int CYC_MS  = cyc_per_ms(SCLK_FREQ);
  localparam int PRE_W   = (CYC_MS > 1) ? $clog2(CYC_MS) : 1;
  localparam int BLK_MAX = (SLOW_MS > FAST_MS) ? SLOW_MS : FAST_MS;
  localparam int BLK_W   = (BLK_MAX > 1) ? $clog2(BLK_MAX) : 1;

  localparam logic [PRE_W-1:0] PRE_TERM  = PRE_W'(CYC_MS - 1);
  localparam logic [BLK_W-1:0] SLOW_TERM = BLK_W'(SLOW_MS - 1);
  localparam logic [BLK_W-1:0] FAST_TERM = BLK_W'(FAST_MS - 1);

  if ((SCLK_FREQ < 1000) || ((SCLK_FREQ % 1000) != 0)) begin : g_bad_freq
    $error("led_mode_ctrl: SCLK_FREQ must be a positive multiple of 1000");
  end

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              key_q;
  logic              evt;
  logic              mode_chg;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              ms_tick;
  logic [BLK_W-1:0]  blink_q, blink_d;
  logic              is_blink;
  logic              blink_term;
  logic              led_q, led_d;
  logic              brth_pwm;

  assign evt        = key_pulse & ~key_q;
  assign mode_chg   = (mode_d != mode_q);
  assign ms_tick    = (presc_q == PRE_TERM);
  assign is_blink   = (mode_q == MODE_SLOW) || (mode_q == MODE_FAST);
  assign blink_term = ms_tick &&
                      (blink_q == ((mode_q == MODE_FAST) ? FAST_TERM : SLOW_TERM));

  // Mode state register
  always_ff @(posedge sclk) begin
    if (rst) mode_q <= MODE_OFF;
    else     mode_q <= mode_d;
  end

  // Next mode: advance on each key edge; any unused code falls back to OFF
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_OFF:     if (evt) mode_d = MODE_ON;
      MODE_ON:      if (evt) mode_d = MODE_SLOW;
      MODE_SLOW:    if (evt) mode_d = MODE_FAST;
      MODE_FAST:    if (evt) mode_d = MODE_BREATHE;
      MODE_BREATHE: if (evt) mode_d = MODE_OFF;
      default:      mode_d = MODE_OFF;
    endcase
  end

  // Prescaler and blink counter next values; a mode change restarts both
  always_comb begin
    presc_d = ms_tick ? '0 : presc_q + 1'b1;
    blink_d = blink_q;
    if (is_blink && ms_tick) blink_d = blink_term ? '0 : blink_q + 1'b1;
    if (mode_chg) begin
      presc_d = '0;
      blink_d = '0;
    end
  end

  // Edge-detect register and timing counters
  always_ff @(posedge sclk) begin
    if (rst) begin
      key_q   <= 1'b0;
      presc_q <= '0;
      blink_q <= '0;
    end else begin
      key_q   <= key_pulse;
      presc_q <= presc_d;
      blink_q <= blink_d;
    end
  end

  // Output select: entry value on a mode change, otherwise the mode's own waveform
  always_comb begin
    led_d = 1'b0;
    if (mode_chg) begin
      led_d = (mode_d == MODE_ON) || (mode_d == MODE_SLOW) || (mode_d == MODE_FAST);
    end else begin
      case (mode_q)
        MODE_ON:              led_d = 1'b1;
        MODE_SLOW, MODE_FAST: led_d = led_q ^ blink_term;
        MODE_BREATHE:         led_d = brth_pwm;
        default:              led_d = 1'b0;
      endcase
    end
  end

  // Registered LED drive
  always_ff @(posedge sclk) begin
    if (rst) led_q <= 1'b0;
    else     led_q <= led_d;
  end

  led_breath #(
    .CYC_MS   (CYC_MS),
    .BREATH_MS(BREATH_MS),
    .PWM_BITS (PWM_BITS)
  ) u_breath (
    .sclk   (sclk),
    .rst    (rst),
    .clr    (mode_chg),
    .en     (mode_q == MODE_BREATHE),
    .pwm_out(brth_pwm)
  );

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - scoreboard bench for led_mode_ctrl
module tb_led_mode_ctrl;

  localparam int M_OFF = 0;
  localparam int M_ON  = 1;
  localparam int M_SLW = 2;
  localparam int M_FST = 3;
  localparam int M_BR  = 4;

  localparam int SLOW_I = 8;
  localparam int FAST_I = 3;
  localparam int FRAME  = 8;
  localparam int STEP   = 18;
  localparam int DMAX   = 7;

  typedef struct {
    logic [2:0] mode;
    logic       led;
    bit         chk_duty;
    int         duty;
  } exp_t;

  logic       sclk;
  logic       rst;
  logic       key_pulse;
  logic       led;
  logic [2:0] mode;

  exp_t exp_q[$];
  int   n_chk;
  int   n_err;

  led_mode_ctrl #(
    .SCLK_FREQ(1000),
    .SLOW_MS  (8),
    .FAST_MS  (3),
    .BREATH_MS(252),
    .PWM_BITS (3)
  ) dut (
    .sclk     (sclk),
    .rst      (rst),
    .key_pulse(key_pulse),
    .led      (led),
    .mode     (mode)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // triangle 0..7..0 with period 2*DMAX steps
  function automatic int tri_v(input int n);
    int r;
    r = n % (2 * DMAX);
    return (r <= DMAX) ? r : (2 * DMAX) - r;
  endfunction

  // duty applied during PWM frame f after breathe entry
  function automatic int duty_of_frame(input int f);
    if (f == 0) return 0;
    return tri_v((FRAME * f - 1) / STEP);
  endfunction

  // expected led k cycles after entering mode m (k=0 is the first cycle in the mode)
  function automatic logic exp_led(input int m, input int k);
    case (m)
      M_ON:  return 1'b1;
      M_SLW: return ((k / SLOW_I) % 2) == 0;
      M_FST: return ((k / FAST_I) % 2) == 0;
      M_BR: begin
        if (k == 0) return 1'b0;
        return ((k - 1) % FRAME) < duty_of_frame((k - 1) / FRAME);
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t mk(input int m, input int k);
    exp_t e;
    e.mode     = 3'(m);
    e.led      = exp_led(m, k);
    e.chk_duty = (m == M_BR) && ((k % FRAME) == 0);
    e.duty     = duty_of_frame(k / FRAME);
    return e;
  endfunction

  task automatic drive(input logic k, input logic r, input exp_t e);
    exp_q.push_back(e);
    key_pulse = k;
    rst       = r;
    @(posedge sclk);
    #1;
  endtask

  task automatic pulse_to(input int m);
    drive(1'b1, 1'b0, mk(m, 0));
  endtask

  task automatic hold(input int m, input int k0, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, mk(m, k0 + i));
  endtask

  // monitor: pop one expectation per cycle and compare
  always @(negedge sclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mode", int'(mode), int'(e.mode));
      chk("led", int'(led), int'(e.led));
      if (e.chk_duty) chk("duty_q", int'(dut.u_breath.duty_q), e.duty);
    end
  end

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    key_pulse = 1'b0;

    // reset held 5 cycles, then one cycle after release
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, mk(M_OFF, 0));
    hold(M_OFF, 0, 1);

    // single pulses through every mode, back to OFF and on to ON
    pulse_to(M_ON);  hold(M_ON, 1, 19);
    pulse_to(M_SLW); hold(M_SLW, 1, 39);
    pulse_to(M_FST); hold(M_FST, 1, 19);
    pulse_to(M_BR);  hold(M_BR, 1, 269);
    pulse_to(M_OFF); hold(M_OFF, 1, 19);
    pulse_to(M_ON);  hold(M_ON, 1, 19);

    // reset in the middle of a slow blink
    pulse_to(M_SLW); hold(M_SLW, 1, 11);
    drive(1'b0, 1'b1, mk(M_OFF, 0));
    hold(M_OFF, 1, 3);

    // key held high for 10 cycles counts once
    pulse_to(M_ON);
    for (int i = 1; i < 10; i++) drive(1'b1, 1'b0, mk(M_ON, i));
    hold(M_ON, 10, 3);

    // two pulses separated by one low cycle
    pulse_to(M_SLW); hold(M_SLW, 1, 1);
    pulse_to(M_FST); hold(M_FST, 1, 2);

    // pulse on the cycle the fast blink would toggle
    pulse_to(M_BR);  hold(M_BR, 1, 40);

    // reset together with a pulse
    drive(1'b1, 1'b1, mk(M_OFF, 0));
    hold(M_OFF, 1, 2);
    pulse_to(M_ON);  hold(M_ON, 1, 2);

    @(negedge sclk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
